fp_add_pipe: RTL
================

Name: fp_add_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 adder/subtractor with runtime rounding mode and exception flags.
- Successor to the combinational add + rounding pair. Adds configurable exponent/mantissa widths, valid/ready streaming with backpressure, a subtract op, and RISC-V style fflags.
- Sits between the operand issue logic and the FP result writeback.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width. Word width W = 1+EXP_W+MANT_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- in1  in  W  operand A
- in2  in  W  operand B
- sub  in  1  1: A-B (in2 sign inverted at stage 1), 0: A+B
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, 101-111 treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  W  packed result
- flags  out  5  {NV,DZ,OF,UF,NX}; DZ always 0

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, out_valid = 0, out = 0, flags = 0, in_ready = 1.
- Beat transfers on in_valid && in_ready. Result transfers on out_valid && out_ready.
- Latency: exactly 3 cycles from accept to out_valid when not stalled. Throughput: 1 beat/cycle.
- Stall = out_valid && !out_ready. On stall every stage register holds and in_ready = 0 (combinational). No beat is lost or reordered. out and flags stay stable while stalled.
- Bubbles propagate: stage valids shift independently of data.
- Stage 1:
  - Unpack and classify each operand: zero, subnormal, normal, inf, sNaN, qNaN. Subnormals use exponent 1 with hidden bit 0.
  - Swap so the larger magnitude is operand A.
  - Align B by the exponent difference into a guard/round/sticky-extended mantissa. Shift saturates at MANT_W+3; all shifted-out bits OR into sticky.
- Stage 2:
  - Effective add/sub of the aligned mantissas.
  - Leading-zero count and normalise.
  - Left shift is limited so the exponent does not go below 1 (subnormal result).
  - Carry-out causes a right shift by 1 with sticky preserved.
- Stage 3:
  - Round per rm using G/R/S. Mantissa carry from rounding increments the exponent.
  - Pack the result and compute flags.
- Special cases, in priority order:
  - Any sNaN, or inf - inf (effective subtract of opposite infinities): result canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0), NV = 1.
  - Any qNaN: canonical qNaN, no flags.
  - Otherwise an inf input: result is that inf.
- Exact zero sum of opposite-signed operands: -0 under RDN, +0 otherwise. Same-signed zeros keep the shared sign.
- Overflow (rounded exp >= all ones): OF = 1, NX = 1. Result is:
  - RNE, RMM: inf.
  - RTZ: max finite.
  - RDN: -inf if negative, else +max finite.
  - RUP: +inf if positive, else -max finite.
- NX = 1 when any of G/R/S is non-zero.
- UF = 1 when the result is tiny (after rounding) and inexact.

Optional Feature:
- Macro FP_ADD_DAZ_FTZ_EN.
- Defined:
  - Subnormal inputs are treated as zero of the same sign.
  - A subnormal rounded result is flushed to zero of the same sign, with UF = 1 and NX = 1.
- Undefined: full gradual-underflow support as described above.

Test Plan:
- 0x3F800000 + 0x3F800000, rm=RNE, sub=0 -> out 0x40000000, flags 0, out_valid exactly 3 cycles after accept.
- 0x3F800000 + 0x33800000 (tie) -> RNE 0x3F800000 NX, RUP 0x3F800001 NX, RMM 0x3F800001 NX, RTZ 0x3F800000 NX. Also 0x3F800000 - 0x3F800000 -> RNE 0x00000000, RDN 0x80000000, flags 0.
- 0x7F7FFFFF + 0x7F7FFFFF -> RNE 0x7F800000, RTZ 0x7F7FFFFF, RDN 0x7F7FFFFF; flags OF|NX (0x05) in all three.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000 NV (0x10). 0x7F800001 + 0x3F800000 -> 0x7FC00000 NV. 0x7FC00000 + 0x3F800000 -> 0x7FC00000, flags 0.
- Subnormals: 0x00000001 + 0x00000001 -> 0x00000002, flags 0. 0x00800000 - 0x00000001 -> 0x007FFFFF, flags 0. With FP_ADD_DAZ_FTZ_EN: first case -> 0x00000000.
- Backpressure:
  - 6 back-to-back beats, out_ready held low 5 cycles after the first out_valid -> in_ready low during the stall; all 6 results appear in order with correct values; out stable while stalled.
  - rst_n pulsed mid-stream -> out_valid 0 immediately; no stale results after release.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage IEEE-754 adder/subtractor with valid/ready, runtime rounding and fflags.
// Define FP_ADD_DAZ_FTZ_EN to treat subnormal inputs as zero and flush subnormal results to zero.
module fp_add_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] in1,
  input  logic [EXP_W+MANT_W:0] in2,
  input  logic                  sub,
  input  logic [2:0]            rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] out,
  output logic [4:0]            flags
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int XW = MANT_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int RW = EW + MANT_W;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  function automatic logic [MANT_W:0] sig_of(input logic [W-1:0] v);
`ifdef FP_ADD_DAZ_FTZ_EN
    return (|v[W-2:MANT_W]) ? {1'b1, v[MANT_W-1:0]} : '0;
`else
    return {|v[W-2:MANT_W], v[MANT_W-1:0]};
`endif
  endfunction

  function automatic int lzc(input logic [XW-1:0] v);
    int n = XW;
    for (int i = 0; i < XW; i++)
      if (v[i]) n = XW - 1 - i;
    return n;
  endfunction

  function automatic logic round_up(input logic [2:0] mode, input logic sign,
                                    input logic lsb, input logic [2:0] grs);
    case (mode)
      RTZ:     return 1'b0;
      RDN:     return sign & (|grs);
      RUP:     return ~sign & (|grs);
      RMM:     return grs[2];
      default: return grs[2] & (lsb | grs[1] | grs[0]);
    endcase
  endfunction

  function automatic logic [W-1:0] ovf_result(input logic [2:0] mode, input logic sign);
    logic to_inf;
    case (mode)
      RTZ:     to_inf = 1'b0;
      RDN:     to_inf = sign;
      RUP:     to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    return to_inf ? {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                  : {sign, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
  endfunction

  logic adv, vld_p1_q, vld_p2_q, out_valid_q;
  assign adv       = ~(out_valid_q & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q    <= in_valid;
      vld_p2_q    <= vld_p1_q;
      out_valid_q <= vld_p2_q;
    end
  end

  // Stage 1: unpack, classify, swap so A has the larger magnitude, align B with sticky
  logic sgn_a, sgn_b, nan_a, nan_b, inf_a, inf_b, swap;
  logic [EXP_W-1:0] ex_a, ex_b, ex_dif;
  logic [MANT_W:0] mn_a, mn_b, mn_sml;
  logic [2*XW-1:0] algn;
  int al_sh;
  logic sgn_p1_d, eff_sub_p1_d, spec_p1_d, nv_p1_d;
  logic [EXP_W-1:0] exp_p1_d;
  logic [XW-1:0] ma_p1_d, mb_p1_d;
  logic [W-1:0] sval_p1_d;
  logic [2:0] rm_p1_d;

  always_comb begin
    sgn_a = in1[W-1];
    sgn_b = in2[W-1] ^ sub;
    nan_a = (&in1[W-2:MANT_W]) & (|in1[MANT_W-1:0]);
    nan_b = (&in2[W-2:MANT_W]) & (|in2[MANT_W-1:0]);
    inf_a = (&in1[W-2:MANT_W]) & ~(|in1[MANT_W-1:0]);
    inf_b = (&in2[W-2:MANT_W]) & ~(|in2[MANT_W-1:0]);
    ex_a  = (|in1[W-2:MANT_W]) ? in1[W-2:MANT_W] : EXP_W'(1);
    ex_b  = (|in2[W-2:MANT_W]) ? in2[W-2:MANT_W] : EXP_W'(1);
    mn_a  = sig_of(in1);
    mn_b  = sig_of(in2);
    swap  = {ex_b, mn_b} > {ex_a, mn_a};
    exp_p1_d = swap ? ex_b : ex_a;
    ex_dif   = swap ? (ex_b - ex_a) : (ex_a - ex_b);
    mn_sml   = swap ? mn_a : mn_b;
    ma_p1_d  = {swap ? mn_b : mn_a, 3'b000};
    al_sh    = (int'(ex_dif) > MANT_W + 3) ? MANT_W + 3 : int'(ex_dif);
    algn     = {mn_sml, 3'b000, {XW{1'b0}}} >> al_sh;
    mb_p1_d  = {algn[2*XW-1:XW+1], algn[XW] | (|algn[XW-1:0])};
    sgn_p1_d     = swap ? sgn_b : sgn_a;
    eff_sub_p1_d = sgn_a ^ sgn_b;
    rm_p1_d      = (rm > RMM) ? RNE : rm;
    nv_p1_d   = (nan_a & ~in1[MANT_W-1]) | (nan_b & ~in2[MANT_W-1]) | (inf_a & inf_b & (sgn_a ^ sgn_b));
    spec_p1_d = nan_a | nan_b | inf_a | inf_b;
    if (nv_p1_d || nan_a || nan_b) sval_p1_d = QNAN;
    else if (inf_a)                sval_p1_d = {sgn_a, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else                           sval_p1_d = {sgn_b, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
  end

  logic sgn_p1_q, eff_sub_p1_q, spec_p1_q, nv_p1_q;
  logic [EXP_W-1:0] exp_p1_q;
  logic [XW-1:0] ma_p1_q, mb_p1_q;
  logic [W-1:0] sval_p1_q;
  logic [2:0] rm_p1_q;

  always_ff @(posedge clk) begin
    if (adv) begin
      sgn_p1_q     <= sgn_p1_d;
      eff_sub_p1_q <= eff_sub_p1_d;
      spec_p1_q    <= spec_p1_d;
      nv_p1_q      <= nv_p1_d;
      exp_p1_q     <= exp_p1_d;
      ma_p1_q      <= ma_p1_d;
      mb_p1_q      <= mb_p1_d;
      sval_p1_q    <= sval_p1_d;
      rm_p1_q      <= rm_p1_d;
    end
  end

  // Stage 2: effective add/sub, then normalise without letting the exponent drop below 1
  logic [XW:0] sum;
  logic [XW-1:0] nrm;
  logic [EW-1:0] nexp, exp_p2_d;
  logic [MANT_W-1:0] frac_p2_d;
  logic [2:0] grs_p2_d;
  logic sgn_p2_d;
  int lz, nsh;

  always_comb begin
    sum = eff_sub_p1_q ? ({1'b0, ma_p1_q} - {1'b0, mb_p1_q}) : ({1'b0, ma_p1_q} + {1'b0, mb_p1_q});
    lz  = lzc(sum[XW-1:0]);
    nsh = (lz < int'(exp_p1_q) - 1) ? lz : int'(exp_p1_q) - 1;
    if (sum[XW]) begin
      nrm  = {sum[XW:2], sum[1] | sum[0]};
      nexp = EW'(exp_p1_q) + EW'(1);
    end else begin
      nrm  = sum[XW-1:0] << nsh;
      nexp = EW'(exp_p1_q) - EW'(nsh);
    end
    exp_p2_d  = nrm[XW-1] ? nexp : '0;
    frac_p2_d = nrm[XW-2:3];
    grs_p2_d  = nrm[2:0];
    sgn_p2_d  = (~(|sum) && eff_sub_p1_q) ? (rm_p1_q == RDN) : sgn_p1_q;
  end

  logic sgn_p2_q, spec_p2_q, nv_p2_q;
  logic [EW-1:0] exp_p2_q;
  logic [MANT_W-1:0] frac_p2_q;
  logic [2:0] grs_p2_q, rm_p2_q;
  logic [W-1:0] sval_p2_q;

  always_ff @(posedge clk) begin
    if (adv) begin
      sgn_p2_q  <= sgn_p2_d;
      spec_p2_q <= spec_p1_q;
      nv_p2_q   <= nv_p1_q;
      exp_p2_q  <= exp_p2_d;
      frac_p2_q <= frac_p2_d;
      grs_p2_q  <= grs_p2_d;
      rm_p2_q   <= rm_p1_q;
      sval_p2_q <= sval_p1_q;
    end
  end

  // Stage 3: round on {exp,frac} so a mantissa carry bumps the exponent, then pack and flag
  logic up, inexact;
  logic [RW-1:0] rnd;
  logic [EW-1:0] rexp;
  logic [W-1:0] out_d, out_q;
  logic [4:0] flags_d, flags_q;

  always_comb begin
    up      = round_up(rm_p2_q, sgn_p2_q, frac_p2_q[0], grs_p2_q);
    rnd     = {exp_p2_q, frac_p2_q} + RW'(up);
    rexp    = rnd[RW-1:MANT_W];
    inexact = |grs_p2_q;
    out_d   = {sgn_p2_q, rexp[EXP_W-1:0], rnd[MANT_W-1:0]};
    flags_d = {3'b000, (rexp == '0) & inexact, inexact};
    if (spec_p2_q) begin
      out_d   = sval_p2_q;
      flags_d = {nv_p2_q, 4'b0000};
    end else if (rexp >= EXP_MAX) begin
      out_d   = ovf_result(rm_p2_q, sgn_p2_q);
      flags_d = 5'b00101;
    end
`ifdef FP_ADD_DAZ_FTZ_EN
    else if (rexp == '0 && (|rnd[MANT_W-1:0])) begin
      out_d   = {sgn_p2_q, {(W-1){1'b0}}};
      flags_d = 5'b00011;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else if (adv && vld_p2_q) begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out   = out_q;
  assign flags = flags_q;
endmodule
